// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, plus MTHI/MTLO writes; 33 edges from accept to result.
// No backpressure: busy stalls the controller and any start while busy is dropped.
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  functcode,
    input  logic [31:0] rs_content,
    input  logic [31:0] rt_content,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [5:0] FN_MTHI = 6'h11;
    localparam logic [5:0] FN_MTLO = 6'h13;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2
    } state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [63:0] acc_q;
    logic [31:0] opb_q;
    logic        is_div_q;
    logic        neg_res_q;
    logic        neg_rem_q;
    logic        dz_q;
    logic        busy_q;
    logic        done_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        is_md;
    logic        op_div;
    logic        sa;
    logic        sb;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [63:0] acc_d;
    logic [31:0] opb_d;
    logic [63:0] acc_step;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic        div_ok;
    logic [31:0] div_rem;
    logic [63:0] prod_neg;
    logic [31:0] fix_hi;
    logic [31:0] fix_lo;

    // Operand decode at accept: signed ops work on magnitudes, signs are fixed up at the end.
    always_comb begin
        is_md  = (functcode[5:2] == 4'b0110);
        op_div = functcode[1];
        sa     = ~functcode[0] & rs_content[31];
        sb     = ~functcode[0] & rt_content[31];
        mag_a  = sa ? (32'd0 - rs_content) : rs_content;
        mag_b  = sb ? (32'd0 - rt_content) : rt_content;
        opb_d  = op_div ? mag_b : mag_a;
        acc_d  = {32'd0, (op_div ? mag_a : mag_b)};
    end

    // One radix-2 step. Divide keeps remainder in acc[63:32], dividend/quotient in acc[31:0].
    always_comb begin
        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
        div_shift = {acc_q[63:32], acc_q[31]};
        div_ok    = (div_shift >= {1'b0, opb_q});
        div_rem   = div_ok ? (div_shift[31:0] - opb_q) : div_shift[31:0];
        acc_step  = is_div_q ? {div_rem, acc_q[30:0], div_ok} : {mul_sum, acc_q[31:1]};
    end

    // A zero divisor yields an all-ones quotient and remainder |rs|; signing the remainder restores rs.
    always_comb begin
        prod_neg = 64'd0 - acc_q;
        if (is_div_q) begin
            fix_hi = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
            fix_lo = (neg_res_q & ~dz_q) ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
        end else begin
            fix_hi = neg_res_q ? prod_neg[63:32] : acc_q[63:32];
            fix_lo = neg_res_q ? prod_neg[31:0]  : acc_q[31:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 5'd0;
            acc_q     <= 64'd0;
            opb_q     <= 32'd0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (is_md) begin
                            state_q   <= RUN;
                            busy_q    <= 1'b1;
                            cnt_q     <= 5'd0;
                            acc_q     <= acc_d;
                            opb_q     <= opb_d;
                            is_div_q  <= op_div;
                            neg_res_q <= sa ^ sb;
                            neg_rem_q <= sa;
                            dz_q      <= (rt_content == 32'd0);
                        end else if (functcode == FN_MTHI) begin
                            hi_q <= rs_content;
                        end else if (functcode == FN_MTLO) begin
                            lo_q <= rs_content;
                        end
                    end
                end
                RUN: begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q <= FIXUP;
                    end
                end
                FIXUP: begin
                    hi_q    <= fix_hi;
                    lo_q    <= fix_lo;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
